// File: rtl/clock_mode_ctrl_if.sv
// Button, time-source and edit-value bundle for the front-panel
// mode sequencer.
interface clock_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_hr;
  logic       btn_min;
  logic [7:0] cur_hours;
  logic [7:0] cur_minutes;
  logic [7:0] alm_hours;
  logic [7:0] alm_minutes;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic       set_time;
  logic       set_alarm;
  logic       editing;

  modport master (
    output btn_mode, btn_hr, btn_min,
    output cur_hours, cur_minutes,
    output alm_hours, alm_minutes,
    input  hours, minutes,
    input  set_time, set_alarm, editing
  );

  modport slave (
    input  btn_mode, btn_hr, btn_min,
    input  cur_hours, cur_minutes,
    input  alm_hours, alm_minutes,
    output hours, minutes,
    output set_time, set_alarm, editing
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Front-panel mode sequencer: RUN / SET_TIME / SET_ALARM with BCD
// edit values, auto-repeat increments and an idle timeout.
module clock_mode_ctrl #(
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000,
  parameter int TIMEOUT      = 250_000_000
) (
  input logic              MHz_25,
  input logic              reset,
  clock_mode_ctrl_if.slave bus
);

  localparam int RD_W = $clog2(REPEAT_DELAY + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] SET_TIME  = 2'd1;
  localparam logic [1:0] SET_ALARM = 2'd2;

  localparam logic [RD_W-1:0] RD_TOP =
    RD_W'(REPEAT_DELAY);
  localparam logic [RD_W-1:0] RD_RELOAD =
    RD_W'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam logic [TO_W-1:0] TO_TOP =
    TO_W'(TIMEOUT - 1);

  // bit 2 = mode, bit 1 = hr, bit 0 = min
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] rise;

  logic [1:0]      state_q, state_d;
  logic [7:0]      hours_q, hours_d;
  logic [7:0]      minutes_q, minutes_d;
  logic            set_time_q, set_time_d;
  logic            set_alarm_q, set_alarm_d;
  logic [RD_W-1:0] hr_cnt_q, hr_cnt_d;
  logic [RD_W-1:0] min_cnt_q, min_cnt_d;
  logic [TO_W-1:0] to_q, to_d;

  logic set_st, chg, tmo;
  logic hr_fire, min_fire;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] top
  );
    if (v == top)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    rise        = s2_q & ~s3_q;
    set_st      = (state_q != RUN);
    state_d     = state_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    // fresh button activity holds off the timeout
    tmo         = set_st && (to_q == TO_TOP) && !(|rise);
    hr_fire     = set_st && s2_q[1] && (hr_cnt_q == RD_TOP);
    min_fire    = set_st && s2_q[0] && (min_cnt_q == RD_TOP);

    if (rise[2]) begin
      unique case (state_q)
        RUN: begin
          state_d   = SET_TIME;
          hours_d   = bus.cur_hours;
          minutes_d = bus.cur_minutes;
        end
        SET_TIME: begin
          state_d   = SET_ALARM;
          hours_d   = bus.alm_hours;
          minutes_d = bus.alm_minutes;
        end
        default: state_d = RUN;
      endcase
    end else if (tmo) begin
      state_d = RUN;
    end else if (set_st) begin
      if (rise[1] || hr_fire)
        hours_d = bcd_inc(hours_q, 8'h23);
      if (rise[0] || min_fire)
        minutes_d = bcd_inc(minutes_q, 8'h59);
    end

    chg         = (state_d != state_q);
    set_time_d  = (state_d == SET_TIME);
    set_alarm_d = (state_d == SET_ALARM);

    if (!set_st || !s2_q[1] || chg)
      hr_cnt_d = '0;
    else if (hr_fire)
      hr_cnt_d = RD_RELOAD;
    else
      hr_cnt_d = hr_cnt_q + 1'b1;

    if (!set_st || !s2_q[0] || chg)
      min_cnt_d = '0;
    else if (min_fire)
      min_cnt_d = RD_RELOAD;
    else
      min_cnt_d = min_cnt_q + 1'b1;

    if (!set_st || chg || (|rise))
      to_d = '0;
    else
      to_d = to_q + 1'b1;
  end

  always_ff @(posedge MHz_25 or posedge reset) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      state_q     <= RUN;
      hours_q     <= 8'h00;
      minutes_q   <= 8'h00;
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      hr_cnt_q    <= '0;
      min_cnt_q   <= '0;
      to_q        <= '0;
    end else begin
      s1_q        <= {bus.btn_mode, bus.btn_hr, bus.btn_min};
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      state_q     <= state_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      set_time_q  <= set_time_d;
      set_alarm_q <= set_alarm_d;
      hr_cnt_q    <= hr_cnt_d;
      min_cnt_q   <= min_cnt_d;
      to_q        <= to_d;
    end
  end

  assign bus.hours     = hours_q;
  assign bus.minutes   = minutes_q;
  assign bus.set_time  = set_time_q;
  assign bus.set_alarm = set_alarm_q;
  assign bus.editing   = set_time_q | set_alarm_q;

endmodule
